arst_sync_const_p: RTL and testbench



---
 rtl/arst_sync_pkg.sv | 14 +
 rtl/arst_sync_chain.sv | 33 +++
 rtl/arst_sync_const_p.sv | 72 +++++++
 tb/tb_arst_sync_const_p.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/arst_sync_pkg.sv
`timescale 1ns/1ps
// Shared defaults and sizing helper for the reset conditioner.
package arst_sync_pkg;

  localparam int ARST_SYNC_STAGES_DEF = 2;
  localparam int ARST_HOLD_CYCLES_DEF = 4;

  // Hold counter must reach HOLD_CYCLES; keep at least one bit so the
  // declaration stays legal when no hold is requested.
  function automatic int cnt_width(input int hold_cycles);
    return (hold_cycles < 1) ? 1 : $clog2(hold_cycles + 1);
  endfunction

endpackage

// File: rtl/arst_sync_chain.sv
`timescale 1ns/1ps
// Async-clear shift chain with a constant-1 input: deasserts synchronously,
// clears immediately whenever rst_ni falls.
module arst_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_ni,
  output logic sync_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("arst_sync_chain: STAGES must be >= 2");
  end

  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift a constant 1 in from the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], 1'b1};
  end

  // Chain register; the only reset value is the async clear.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/arst_sync_const_p.sv
`timescale 1ns/1ps
// Reset conditioner: asynchronous assert, synchronous deassert, and a fixed
// minimum low time of SYNC_STAGES + HOLD_CYCLES clk edges after rst_i rises.
module arst_sync_const_p
  import arst_sync_pkg::*;
#(
  parameter int SYNC_STAGES = ARST_SYNC_STAGES_DEF,
  parameter int HOLD_CYCLES = ARST_HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_i,
  output logic rst_o
);

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("arst_sync_const_p: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 0) begin : g_bad_hold
    $error("arst_sync_const_p: HOLD_CYCLES must be >= 0");
  end

  logic sync_w;

  arst_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_chain (
    .clk    (clk),
    .rst_ni (rst_i),
    .sync_o (sync_w)
  );

  if (HOLD_CYCLES == 0) begin : g_no_hold
    // The last synchronizer flop already is a clean flop output.
    assign rst_o = sync_w;
  end else begin : g_hold
    localparam int CNT_W = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
    // rst_o_q is itself a flop, so it must be armed one edge before the
    // counter saturates to rise exactly on edge SYNC_STAGES + HOLD_CYCLES.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rst_o_q;
    logic             rst_o_d;

    // Count edges after the synchronizer releases, saturating at HOLD_CYCLES.
    always_comb begin
      cnt_d = cnt_q;
      if (sync_w && (cnt_q < HOLD_MAX)) cnt_d = cnt_q + CNT_W'(1);
    end

    // Release the output on the final hold edge and keep it high afterwards.
    always_comb begin
      rst_o_d = sync_w && (cnt_q >= HOLD_LAST);
    end

    // Counter and output flops, cleared asynchronously with the chain.
    always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
        cnt_q   <= '0;
        rst_o_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        rst_o_q <= rst_o_d;
      end
    end

    assign rst_o = rst_o_q;
  end

endmodule

// File: tb/tb_arst_sync_const_p.sv
`timescale 1ns/100ps
// Bench: four parameterizations share clk and rst_i; a model counts clk edges
// since the last rst_i rise and expects rst_o high once that count reaches N.
module tb_arst_sync_const_p;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst_i = 1'b1;
  logic [3:0] rst_o;

  int n_of [4] = '{6, 3, 12, 5};

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;
  bit coinc = 1'b0;

  always #5 if (clk_run) clk = ~clk;

  arst_sync_const_p u_d0 (.clk(clk), .rst_i(rst_i), .rst_o(rst_o[0]));
  arst_sync_const_p #(.SYNC_STAGES(3), .HOLD_CYCLES(0))
    u_d1 (.clk(clk), .rst_i(rst_i), .rst_o(rst_o[1]));
  arst_sync_const_p #(.SYNC_STAGES(2), .HOLD_CYCLES(10))
    u_d2 (.clk(clk), .rst_i(rst_i), .rst_o(rst_o[2]));
  arst_sync_const_p #(.SYNC_STAGES(4), .HOLD_CYCLES(1))
    u_d3 (.clk(clk), .rst_i(rst_i), .rst_o(rst_o[3]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: rst_o=%b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clk edge, update the model, and compare every instance.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_i && edges < 1000) edges++;
    #1;
    for (int i = 0; i < 4; i++) begin
      // On the coincident-edge run, edge N itself may go either way.
      if (!(coinc && edges == n_of[i]))
        chk($sformatf("%s_n%0d_e%0d", tag, n_of[i], edges), rst_o[i],
            logic'(edges >= n_of[i]));
    end
  endtask

  task automatic ticks(input string tag, input int k);
    for (int j = 0; j < k; j++) tick(tag);
  endtask

  // Drop rst_i and require every output low within the same nanosecond.
  task automatic fall_check(input string tag);
    rst_i = 1'b0;
    edges = 0;
    coinc = 1'b0;
    #0.5;
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_assert_n%0d", tag, n_of[i]), rst_o[i], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on: real falling edge shortly after time 0.
    #1;
    fall_check("por");
    ticks("por_low", 2);
    #2 rst_i = 1'b1;
    ticks("por", 16);

    // Sub-cycle glitch between edges.
    #3;
    fall_check("glitch");
    #0.5 rst_i = 1'b1;
    ticks("glitch", 16);

    // Reassert part way through the hold sequence.
    #2;
    fall_check("reas1");
    ticks("reas_low", 2);
    #2 rst_i = 1'b1;
    ticks("reas_mid", 3);
    #2;
    fall_check("reas2");
    tick("reas_low2");
    #2 rst_i = 1'b1;
    ticks("reas", 16);

    // Clock stopped low while rst_i pulses.
    @(negedge clk);
    clk_run = 1'b0;
    #3;
    fall_check("stop");
    #7 rst_i = 1'b1;
    #40;
    for (int i = 0; i < 4; i++)
      chk($sformatf("stop_hold_n%0d", n_of[i]), rst_o[i], 1'b0);
    #1 clk_run = 1'b1;
    ticks("stop", 16);

    // Randomized pulses: glitches, multi-cycle lows, arbitrary hold lengths.
    for (int ep = 0; ep < 40; ep++) begin
      #($urandom_range(1, 6));
      fall_check("rnd");
      if ($urandom_range(0, 1) == 0) begin
        #($urandom_range(1, 2));
        rst_i = 1'b1;
      end else begin
        ticks("rnd_low", $urandom_range(1, 4));
        #($urandom_range(1, 6));
        rst_i = 1'b1;
      end
      ticks("rnd", $urandom_range(1, 16));
    end
    ticks("rnd_tail", 14);

    // rst_i rises exactly on a rising clk edge.
    #2;
    fall_check("coinc");
    tick("coinc_low");
    @(posedge clk);
    rst_i = 1'b1;
    coinc = 1'b1;
    edges = 1;
    #1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("coinc_e1_n%0d", n_of[i]), rst_o[i], 1'b0);
    ticks("coinc", 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
